// File: rtl/ce_pkg.sv
// ce_pkg: shared state type, error code and default widths for the CE stream scheduler
package ce_pkg;
  typedef enum logic {IDLE, XFER} state_t;
  localparam logic [1:0] CE_ERR_LEN = 2'b01;
  localparam int W_DATA_DEF = 16;
  localparam int W_PTS_DEF = 12;
  localparam int MAX_INFLIGHT_DEF = 4;
endpackage

// File: rtl/ce_tag_fifo.sv
// ce_tag_fifo: 1-bit channel tag FIFO, depth DEPTH (power of 2), push+pop in one cycle allowed
//   i_push/i_din write a tag, i_pop retires the head, o_empty/o_head expose FIFO state
module ce_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_din,
  output logic o_empty,
  output logic o_head
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] r_mem;
  logic [AW:0] r_wp, r_rp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mem <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_mem[r_wp[AW-1:0]] <= i_din;
      r_wp <= r_wp + {{AW{1'b0}}, i_push};
      r_rp <= r_rp + {{AW{1'b0}}, i_pop};
    end
  assign o_empty = r_wp == r_rp;
  assign o_head = r_mem[r_rp[AW-1:0]];
endmodule

// File: rtl/ce_stream_sched.sv
// ce_stream_sched: packet round-robin scheduler sharing one CE chain between two symbol streams
//   s0_*/s1_*   : requester beat streams (valid/ready, sop/eop, real/imag)
//   m_*         : granted stream forwarded to the CE sink, m_error flags length mismatch
//   ret_*       : read-only tap of the CE source handshake, eop beats retire frames
//   chan_out/chan_vld : channel tag of the frame leaving CE
//   busy, err_len, err_sync, err_orphan : status and single-cycle error pulses
module ce_stream_sched
  import ce_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int W_PTS = W_PTS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic              s1_valid,
  output logic              s0_ready,
  output logic              s1_ready,
  input  logic              s0_sop,
  input  logic              s1_sop,
  input  logic              s0_eop,
  input  logic              s1_eop,
  input  logic [W_DATA-1:0] s0_real,
  input  logic [W_DATA-1:0] s1_real,
  input  logic [W_DATA-1:0] s0_imag,
  input  logic [W_DATA-1:0] s1_imag,
  input  logic [W_PTS-1:0]  fftpts_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sop,
  output logic              m_eop,
  output logic [1:0]        m_error,
  output logic [W_DATA-1:0] m_real,
  output logic [W_DATA-1:0] m_imag,
  input  logic              ret_valid,
  input  logic              ret_ready,
  input  logic              ret_eop,
  output logic              chan_out,
  output logic              chan_vld,
  output logic              busy,
  output logic              err_len,
  output logic              err_sync,
  output logic              err_orphan
);
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  state_t r_state;
  logic r_gnt, r_rr_last;
  logic [W_PTS-1:0] r_pts, r_cnt;
  logic [IW-1:0] r_inflight;
  logic w_xfer, w_req0, w_req1, w_grant, w_sel, w_drop0, w_drop1;
  logic w_sv, w_ssop, w_seop, w_last, w_beat, w_ret, w_pop, w_empty, w_head;
  logic [W_DATA-1:0] w_sreal, w_simag;
  assign w_xfer = r_state == XFER;
  assign w_req0 = s0_valid && s0_sop;
  assign w_req1 = s1_valid && s1_sop;
  assign w_grant = !w_xfer && (w_req0 || w_req1) && r_inflight < IW'(MAX_INFLIGHT);
  assign w_sel = (w_req0 && w_req1) ? !r_rr_last : w_req1;
  // mid-packet beats seen while idle are orphaned and flushed
  assign w_drop0 = !w_xfer && s0_valid && !s0_sop;
  assign w_drop1 = !w_xfer && s1_valid && !s1_sop;
  assign w_sv = r_gnt ? s1_valid : s0_valid;
  assign w_ssop = r_gnt ? s1_sop : s0_sop;
  assign w_seop = r_gnt ? s1_eop : s0_eop;
  assign w_sreal = r_gnt ? s1_real : s0_real;
  assign w_simag = r_gnt ? s1_imag : s0_imag;
  assign w_last = r_cnt == r_pts - W_PTS'(1);
  assign m_valid = w_xfer && w_sv;
  assign w_beat = m_valid && m_ready;
  assign m_sop = m_valid && w_ssop && r_cnt == '0;
  // the packet is closed at the expected length even if the source keeps going
  assign m_eop = m_valid && (w_seop || w_last);
  assign m_error = (m_valid && (w_seop ^ w_last)) ? CE_ERR_LEN : 2'b00;
  assign m_real = w_xfer ? w_sreal : '0;
  assign m_imag = w_xfer ? w_simag : '0;
  assign s0_ready = w_xfer ? (!r_gnt && m_ready) : w_drop0;
  assign s1_ready = w_xfer ? (r_gnt && m_ready) : w_drop1;
  assign busy = w_xfer;
  assign w_ret = ret_valid && ret_ready && ret_eop;
  assign w_pop = w_ret && !w_empty;
  assign chan_vld = !w_empty;
  assign chan_out = !w_empty && w_head;
  ce_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_grant), .i_pop(w_pop), .i_din(w_sel),
    .o_empty(w_empty), .o_head(w_head)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_gnt <= 1'b0;
      r_rr_last <= 1'b1;
      r_pts <= '0;
      r_cnt <= '0;
      r_inflight <= '0;
      err_len <= 1'b0;
      err_sync <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      err_len <= w_beat && (w_seop ^ w_last);
      err_sync <= w_drop0 || w_drop1 || (w_beat && w_ssop && r_cnt != '0);
      err_orphan <= w_ret && w_empty;
      r_inflight <= r_inflight + IW'(w_grant) - IW'(w_pop);
      if (w_grant) begin
        r_state <= XFER;
        r_gnt <= w_sel;
        r_rr_last <= w_sel;
        r_pts <= fftpts_in;
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + W_PTS'(1);
        if (m_eop) r_state <= IDLE;
      end
    end
endmodule

// File: tb/tb_ce_stream_sched.sv
// tb_ce_stream_sched: directed scenarios for the CE stream scheduler
module tb_ce_stream_sched;
  logic clk = 0, rst = 1;
  logic s0_valid = 0, s1_valid = 0, s0_ready, s1_ready;
  logic s0_sop = 0, s1_sop = 0, s0_eop = 0, s1_eop = 0;
  logic [15:0] s0_real = 0, s1_real = 0, s0_imag = 0, s1_imag = 0;
  logic [11:0] fftpts_in = 12'd16;
  logic m_valid, m_ready = 1, m_sop, m_eop;
  logic [1:0] m_error;
  logic [15:0] m_real, m_imag;
  logic ret_valid = 0, ret_ready = 0, ret_eop = 0;
  logic chan_out, chan_vld, busy, err_len, err_sync, err_orphan;
  int checks = 0, errors = 0, cyc = 0;
  int n_len = 0, n_sync = 0, n_orph = 0, len_cyc = 0;
  typedef struct {int cyc; logic sop; logic eop; logic [1:0] err; logic [15:0] re;} beat_t;
  beat_t beats[$];

  ce_stream_sched dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s1_valid(s1_valid), .s0_ready(s0_ready), .s1_ready(s1_ready),
    .s0_sop(s0_sop), .s1_sop(s1_sop), .s0_eop(s0_eop), .s1_eop(s1_eop),
    .s0_real(s0_real), .s1_real(s1_real), .s0_imag(s0_imag), .s1_imag(s1_imag),
    .fftpts_in(fftpts_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop), .m_error(m_error),
    .m_real(m_real), .m_imag(m_imag),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_eop(ret_eop),
    .chan_out(chan_out), .chan_vld(chan_vld), .busy(busy),
    .err_len(err_len), .err_sync(err_sync), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst) begin
      if (m_valid && m_ready) beats.push_back(beat_t'{cyc, m_sop, m_eop, m_error, m_real});
      if (err_len) begin
        n_len++;
        len_cyc = cyc;
      end
      if (err_sync) n_sync++;
      if (err_orphan) n_orph++;
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic v, input logic sop, input logic eop, input logic [15:0] d);
    if (ch == 0) begin
      s0_valid = v; s0_sop = sop; s0_eop = eop; s0_real = d; s0_imag = ~d;
    end else begin
      s1_valid = v; s1_sop = sop; s1_eop = eop; s1_real = d; s1_imag = ~d;
    end
  endtask

  task automatic send(input int ch, input int len);
    logic acc;
    int n;
    for (int i = 0; i < len; i++) begin
      drive(ch, 1'b1, i == 0, i == len - 1, 16'(ch * 256 + i));
      n = 0;
      do begin
        @(negedge clk);
        acc = ch ? s1_ready : s0_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 200);
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL send_timeout ch%0d beat %0d: ready=0 required 1", ch, i);
        break;
      end
    end
    drive(ch, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic ret_pulse();
    ret_valid = 1; ret_ready = 1; ret_eop = 1;
    tick();
    ret_valid = 0; ret_ready = 0; ret_eop = 0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({m_valid, s0_ready, s1_ready, chan_vld, busy, err_len, err_sync, err_orphan, m_error} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {m_valid, s0_ready, s1_ready, chan_vld, busy, err_len, err_sync, err_orphan, m_error});
    end
    rst = 0;
    tick();
  endtask

  task automatic test_round_robin();
    int k0;
    beats.delete();
    fftpts_in = 12'd16;
    k0 = cyc;
    fork
      send(0, 16);
      send(1, 16);
    join
    tick();
    checks++;
    if (beats.size() != 32) begin
      errors++;
      $display("FAIL rr_beat_count: got %0d required 32", beats.size());
    end else begin
      checks++;
      if (beats[0].cyc != k0 + 1 || !beats[0].sop || beats[0].re !== 16'h0000) begin
        errors++;
        $display("FAIL rr_first_ch0: cyc %0d sop %b re %h required cyc %0d sop 1 re 0000", beats[0].cyc, beats[0].sop, beats[0].re, k0 + 1);
      end
      checks++;
      if (!beats[15].eop || beats[16].cyc - beats[15].cyc != 2 || !beats[16].sop || beats[16].re !== 16'h0100) begin
        errors++;
        $display("FAIL rr_second_ch1: eop %b gap %0d sop %b re %h required eop 1 gap 2 sop 1 re 0100", beats[15].eop, beats[16].cyc - beats[15].cyc, beats[16].sop, beats[16].re);
      end
    end
    checks++;
    if (chan_vld !== 1'b1 || chan_out !== 1'b0) begin
      errors++;
      $display("FAIL rr_tag0: vld %b chan %b required vld 1 chan 0", chan_vld, chan_out);
    end
    ret_pulse();
    checks++;
    if (chan_vld !== 1'b1 || chan_out !== 1'b1) begin
      errors++;
      $display("FAIL rr_tag1: vld %b chan %b required vld 1 chan 1", chan_vld, chan_out);
    end
    ret_pulse();
    checks++;
    if (chan_vld !== 1'b0) begin
      errors++;
      $display("FAIL rr_tag_empty: vld %b required 0", chan_vld);
    end
  endtask

  task automatic test_back_to_back();
    int l0, s0c;
    beats.delete();
    l0 = n_len;
    s0c = n_sync;
    repeat (3) send(0, 16);
    tick();
    checks++;
    if (beats.size() != 48 || beats[16].cyc - beats[15].cyc != 2 || beats[32].cyc - beats[31].cyc != 2 ||
        !beats[16].sop || !beats[32].sop || !beats[47].eop) begin
      errors++;
      $display("FAIL b2b_framing: count %0d gap1 %0d gap2 %0d required count 48 gaps 2", beats.size(), beats[16].cyc - beats[15].cyc, beats[32].cyc - beats[31].cyc);
    end
    checks++;
    if (n_len != l0 || n_sync != s0c) begin
      errors++;
      $display("FAIL b2b_no_errors: len %0d sync %0d required 0 0", n_len - l0, n_sync - s0c);
    end
    repeat (3) ret_pulse();
  endtask

  task automatic test_inflight_limit();
    int base, rc;
    fftpts_in = 12'd4;
    repeat (4) send(0, 4);
    base = beats.size();
    fork
      send(1, 4);
    join_none
    repeat (3) begin
      #1;
      checks++;
      if (s1_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL limit_stall: ready %b busy %b required 0 0", s1_ready, busy);
      end
      tick();
    end
    rc = cyc;
    ret_pulse();
    for (int n = 0; n < 100 && beats.size() < base + 4; n++) tick();
    tick();
    checks++;
    if (beats.size() != base + 4) begin
      errors++;
      $display("FAIL limit_fifth_done: beats %0d required %0d", beats.size() - base, 4);
    end else begin
      checks++;
      if (beats[base].cyc != rc + 2 || !beats[base].sop || beats[base].re !== 16'h0100) begin
        errors++;
        $display("FAIL limit_fifth_grant: cyc %0d re %h required cyc %0d re 0100", beats[base].cyc, beats[base].re, rc + 2);
      end
    end
    drive(0, 1'b1, 1'b1, 1'b0, 16'h0);
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || s0_ready !== 1'b0) begin
      errors++;
      $display("FAIL limit_refull: busy %b ready %b required 0 0", busy, s0_ready);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) ret_pulse();
    checks++;
    if (chan_vld !== 1'b1 || chan_out !== 1'b1) begin
      errors++;
      $display("FAIL limit_tag_order: vld %b chan %b required 1 1", chan_vld, chan_out);
    end
    ret_pulse();
  endtask

  task automatic test_short_packet();
    int base, l0;
    fftpts_in = 12'd16;
    base = beats.size();
    l0 = n_len;
    send(0, 10);
    tick();
    checks++;
    if (beats.size() != base + 10 || !beats[base + 9].eop || beats[base + 9].err !== 2'b01 || beats[base + 8].err !== 2'b00) begin
      errors++;
      $display("FAIL short_error_beat: count %0d err %b required count 10 err 01", beats.size() - base, beats[beats.size() - 1].err);
    end
    checks++;
    if (n_len != l0 + 1 || len_cyc != beats[beats.size() - 1].cyc + 1) begin
      errors++;
      $display("FAIL short_err_len: pulses %0d at %0d required 1 at %0d", n_len - l0, len_cyc, beats[beats.size() - 1].cyc + 1);
    end
    base = beats.size();
    send(0, 16);
    tick();
    checks++;
    if (beats.size() != base + 16 || beats[base + 15].err !== 2'b00 || !beats[base].sop || n_len != l0 + 1) begin
      errors++;
      $display("FAIL short_next_ok: count %0d err %b len %0d required 16 00 1", beats.size() - base, beats[beats.size() - 1].err, n_len - l0);
    end
    repeat (2) ret_pulse();
  endtask

  task automatic test_long_packet();
    int base, l0, s0c;
    base = beats.size();
    l0 = n_len;
    s0c = n_sync;
    send(0, 20);
    tick();
    checks++;
    if (beats.size() != base + 16 || !beats[base + 15].eop || beats[base + 15].err !== 2'b01 || beats[base + 15].re !== 16'h000f) begin
      errors++;
      $display("FAIL long_forced_eop: count %0d eop %b err %b required 16 1 01", beats.size() - base, beats[beats.size() - 1].eop, beats[beats.size() - 1].err);
    end
    checks++;
    if (n_len != l0 + 1 || n_sync != s0c + 4) begin
      errors++;
      $display("FAIL long_pulses: len %0d sync %0d required 1 4", n_len - l0, n_sync - s0c);
    end
    ret_pulse();
  endtask

  task automatic test_orphan_and_reset();
    ret_valid = 1; ret_ready = 1; ret_eop = 1;
    tick();
    ret_valid = 0; ret_ready = 0; ret_eop = 0;
    checks++;
    if (err_orphan !== 1'b1 || chan_vld !== 1'b0) begin
      errors++;
      $display("FAIL orphan_pulse: orphan %b vld %b required 1 0", err_orphan, chan_vld);
    end
    tick();
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL orphan_single: orphan %b required 0", err_orphan);
    end
    drive(0, 1'b1, 1'b1, 1'b0, 16'h0);
    tick();
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b1 || chan_vld !== 1'b1) begin
      errors++;
      $display("FAIL midxfer_setup: busy %b valid %b vld %b required 1 1 1", busy, m_valid, chan_vld);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || chan_vld !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid %b busy %b vld %b required 0 0 0", m_valid, busy, chan_vld);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    rst = 0;
    tick();
    fftpts_in = 12'd4;
    repeat (4) send(1, 4);
    checks++;
    if (chan_vld !== 1'b1 || chan_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_inflight: vld %b chan %b required 1 1", chan_vld, chan_out);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_inflight_limit();
    test_short_packet();
    test_long_packet();
    test_orphan_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
